// File: rtl/blctrl_pkg.sv
// blctrl_pkg: shared definitions for the BL-Ctrl I2C speed-write scheduler.
//   - state_t           : scheduler FSM state encoding (also exported for debug)
//   - NUM_MOTORS        : number of motor channels handled per frame
//   - BLCTRL_BASE_ADDR  : default 7-bit I2C address of motor 1
//   - speed_byte()      : picks the speed byte of motor index idx (0 = motor 1)
//                         out of the flattened 64-bit speed vector
package blctrl_pkg;

  localparam int NUM_MOTORS = 8;
  localparam logic [6:0] BLCTRL_BASE_ADDR = 7'h29;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_NEXT  = 3'd5
  } state_t;

  // Motor 1 lives in the most significant byte, so index idx starts at
  // bit 8*(7-idx).
  function automatic logic [7:0] speed_byte(input logic [63:0] flat,
                                            input logic [2:0]  idx);
    logic [5:0] lsb;
    lsb = {3'd7 - idx, 3'b000};
    return flat[lsb +: 8];
  endfunction

endpackage

// File: rtl/blctrl_refresh_timer.sv
// blctrl_refresh_timer: free-running refresh period counter.
// Counts 0..REFRESH_CYCLES-1 while enabled and wraps; o_tick is high during
// the terminal count. When disabled the counter is held at 0.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_en     count enable (scheduler master enable)
//   o_tick   one-cycle refresh tick
module blctrl_refresh_timer #(
  parameter int REFRESH_CYCLES = 32000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == TERM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && w_term;

endmodule

// File: rtl/blctrl_scheduler.sv
// blctrl_scheduler: once per refresh period snapshots the eight motor speeds
// and enables, then walks the enabled motors in order issuing one single-byte
// I2C write per motor and waiting for done, NACK or timeout.
//
// Optional feature macro: BLCTRL_SCHED_RETRY_EN
//   defined   -> the first failure (NACK or timeout) of a motor in a frame
//                re-issues the identical write once; the second result counts.
//   undefined -> a failure moves straight on to the next motor.
//
// Handshake: a write command is transferred on a cycle where o_wr_valid and
// i_wr_ready are both high; while o_wr_valid is high without i_wr_ready,
// o_wr_valid, o_wr_addr and o_wr_data stay unchanged. i_wr_nack is only
// meaningful together with the one-cycle i_wr_done pulse.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_master_en             enables refresh scheduling
//   i_motor_en[7:0]         per-motor enable, bit 0 = motor 1
//   i_speed_flat[63:0]      motor 1 in [63:56] ... motor 8 in [7:0]
//   o_wr_valid / i_wr_ready write command handshake
//   o_wr_addr[6:0]          target address (BASE_ADDR + motor index)
//   o_wr_data[7:0]          speed byte
//   i_wr_done, i_wr_nack    transaction finished / NACKed
//   o_motor_ok[7:0]         last attempt result per motor (1 = ACKed)
//   o_busy                  high outside IDLE
//   o_overrun               one-cycle pulse when a refresh tick was dropped
//   o_dbg_state[2:0]        current FSM state (state_t encoding)
module blctrl_scheduler
  import blctrl_pkg::*;
#(
  parameter int          REFRESH_CYCLES = 32000,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [6:0]  BASE_ADDR      = BLCTRL_BASE_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_master_en,
  input  logic [7:0]  i_motor_en,
  input  logic [63:0] i_speed_flat,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [6:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_done,
  input  logic        i_wr_nack,
  output logic [7:0]  o_motor_ok,
  output logic        o_busy,
  output logic        o_overrun,
  output logic [2:0]  o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [63:0]   r_snap_speed;
  logic [7:0]    r_snap_en;
  logic [TW-1:0] r_tmo;
  logic          r_wr_valid;
  logic [6:0]    r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_motor_ok;
  logic          r_busy;
  logic          r_overrun;

  logic          w_tick;
  logic          w_tmo_expired;
  logic          w_fail;
  logic          w_can_retry;

`ifdef BLCTRL_SCHED_RETRY_EN
  logic          r_retry;
  assign w_can_retry = !r_retry;
`else
  assign w_can_retry = 1'b0;
`endif

  blctrl_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_master_en),
    .o_tick (w_tick)
  );

  assign w_tmo_expired = (r_tmo == TMO_LAST);
  // A done pulse on the expiry cycle takes precedence over the timeout.
  assign w_fail = i_wr_done ? i_wr_nack : w_tmo_expired;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= 3'd0;
      r_snap_speed <= 64'd0;
      r_snap_en    <= 8'd0;
      r_tmo        <= '0;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= 7'd0;
      r_wr_data    <= 8'd0;
      r_motor_ok   <= 8'd0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef BLCTRL_SCHED_RETRY_EN
      r_retry      <= 1'b0;
`endif
    end else begin
      // A tick that arrives while a frame is running is dropped and reported.
      r_overrun <= w_tick && (r_state != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          r_snap_speed <= i_speed_flat;
          r_snap_en    <= i_motor_en;
          r_idx        <= 3'd0;
          r_state      <= ST_SCAN;
        end

        ST_SCAN: begin
`ifdef BLCTRL_SCHED_RETRY_EN
          r_retry <= 1'b0;
`endif
          if (r_snap_en[r_idx]) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= BASE_ADDR + {4'b0000, r_idx};
            r_wr_data  <= speed_byte(r_snap_speed, r_idx);
            r_state    <= ST_ISSUE;
          end else begin
            r_motor_ok[r_idx] <= 1'b0;
            r_state           <= ST_NEXT;
          end
        end

        ST_ISSUE: begin
          if (i_wr_ready) begin
            r_wr_valid <= 1'b0;
            r_tmo      <= '0;
            r_state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (i_wr_done || w_tmo_expired) begin
            if (w_fail && w_can_retry) begin
              // addr/data registers still hold the failed command
              r_wr_valid <= 1'b1;
              r_state    <= ST_ISSUE;
`ifdef BLCTRL_SCHED_RETRY_EN
              r_retry    <= 1'b1;
`endif
            end else begin
              r_motor_ok[r_idx] <= !w_fail;
              r_state           <= ST_NEXT;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        ST_NEXT: begin
          // Dropping master_en ends the frame here; unvisited motor_ok bits
          // keep their previous values.
          if ((r_idx == 3'd7) || !i_master_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= ST_SCAN;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_wr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_motor_ok  = r_motor_ok;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_blctrl_scheduler.sv
// tb_blctrl_scheduler: directed scoreboard bench for blctrl_scheduler.
// Frame scenarios push the expected {addr,data} writes into exp_q; a monitor
// pops and compares on every command transfer. A responder process plays the
// I2C master (done/nack after a programmable delay, or silence).
module tb_blctrl_scheduler;

  localparam int REFRESH = 128;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        master_en = 1'b0;
  logic [7:0]  motor_en = 8'h00;
  logic [63:0] speed_flat = 64'h0;
  logic        wr_ready = 1'b1;
  logic        wr_done = 1'b0;
  logic        wr_nack = 1'b0;
  logic        o_wr_valid;
  logic [6:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic [7:0]  o_motor_ok;
  logic        o_busy;
  logic        o_overrun;
  logic [2:0]  o_dbg_state;

  blctrl_scheduler #(
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TIMEOUT),
    .BASE_ADDR     (7'h29)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_master_en (master_en),
    .i_motor_en  (motor_en),
    .i_speed_flat(speed_flat),
    .o_wr_valid  (o_wr_valid),
    .i_wr_ready  (wr_ready),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .i_wr_done   (wr_done),
    .i_wr_nack   (wr_nack),
    .o_motor_ok  (o_motor_ok),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [14:0] exp_q[$];
  int          done_delay = 3;
  logic [6:0]  nack_a = 7'h0;
  logic [6:0]  drop_a = 7'h0;
  int          ovr_cnt = 0;
  int          wait_run = 0;
  int          wait_max = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic bad(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got=no event expected=event within bound", name);
  endtask

  // ---------------- responder (I2C master model) ----------------
  logic [6:0] resp_addr;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && o_wr_valid && wr_ready) begin
        resp_addr = o_wr_addr;
        @(posedge clk);
        if (resp_addr != drop_a) begin
          repeat (done_delay - 1) @(posedge clk);
          #1;
          wr_done = 1'b1;
          wr_nack = (resp_addr == nack_a);
          @(posedge clk);
          #1;
          wr_done = 1'b0;
          wr_nack = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [6:0]  prev_addr = 7'h0;
  logic [7:0]  prev_data = 8'h0;
  logic [14:0] exp_item;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_hs)
          check("valid_drop_after_accept", o_wr_valid, 1'b0);
        else if (prev_valid && o_wr_valid) begin
          check("addr_stable", o_wr_addr, prev_addr);
          check("data_stable", o_wr_data, prev_data);
        end
        if (o_overrun) ovr_cnt++;
        if (o_dbg_state == 3'd4) wait_run++;
        else begin
          if (wait_run > wait_max) wait_max = wait_run;
          wait_run = 0;
        end
        if (o_wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got=%0h expected=none", {o_wr_addr, o_wr_data});
          end else begin
            exp_item = exp_q.pop_front();
            check("write_addr_data", {o_wr_addr, o_wr_data}, exp_item);
          end
        end
      end
      prev_valid = rst_n && o_wr_valid;
      prev_hs    = rst_n && o_wr_valid && wr_ready;
      prev_addr  = o_wr_addr;
      prev_data  = o_wr_data;
    end
  end

  // ---------------- driver: one refresh frame ----------------
  task automatic run_frame(input string tag, input logic [7:0] en, input logic [63:0] spd,
                           input logic [6:0] nack_addr, input logic [6:0] drop_addr,
                           input int delay, input int hold, input logic [6:0] stop_addr,
                           input logic [7:0] exp_ok, input int exp_ovr, input int exp_wait);
    int n;
    logic [6:0] a;
    logic [7:0] d;
    motor_en   = en;
    speed_flat = spd;
    nack_a     = nack_addr;
    drop_a     = drop_addr;
    done_delay = delay;
    wr_ready   = (hold == 0);
    master_en  = 1'b1;
    ovr_cnt    = 0;
    wait_max   = 0;
    wait_run   = 0;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) begin
        a = 7'h29 + 7'(i);
        d = 8'(spd >> (56 - 8 * i));
        exp_q.push_back({a, d});
`ifdef BLCTRL_SCHED_RETRY_EN
        if (a == nack_addr || a == drop_addr) exp_q.push_back({a, d});
`endif
        if (a == stop_addr) break;
      end
    end
    n = 0;
    while (!o_busy && n < 400) begin @(negedge clk); n++; end
    if (!o_busy) bad({tag, "_busy_rise"});
    if (en[0] && hold == 0) begin
      @(negedge clk);
      check({tag, "_scan_no_valid"}, o_wr_valid, 1'b0);
      @(negedge clk);
      check({tag, "_tick_to_valid"}, o_wr_valid, 1'b1);
    end
    if (hold > 0) begin
      n = 0;
      while (!o_wr_valid && n < 100) begin @(negedge clk); n++; end
      if (!o_wr_valid) bad({tag, "_valid_rise"});
      repeat (hold) @(negedge clk);
      check({tag, "_valid_held"}, o_wr_valid, 1'b1);
      @(posedge clk);
      #1 wr_ready = 1'b1;
    end
    if (stop_addr != 7'h0) begin
      n = 0;
      while (!(o_wr_valid && wr_ready && o_wr_addr == stop_addr) && n < 400) begin
        @(negedge clk); n++;
      end
      if (n >= 400) bad({tag, "_stop_issue"});
      @(posedge clk);
      #1 master_en = 1'b0;
    end
    n = 0;
    while (o_busy && n < 2000) begin @(negedge clk); n++; end
    if (o_busy) bad({tag, "_busy_fall"});
    @(negedge clk);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    check({tag, "_motor_ok"}, o_motor_ok, exp_ok);
    check({tag, "_overrun_count"}, ovr_cnt, exp_ovr);
    check({tag, "_wait_len"}, wait_max, exp_wait);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_valid", o_wr_valid, 1'b0);
    check("reset_wr_addr", o_wr_addr, 7'h0);
    check("reset_wr_data", o_wr_data, 8'h0);
    check("reset_motor_ok", o_motor_ok, 8'h0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_overrun", o_overrun, 1'b0);
    check("reset_state", o_dbg_state, 3'd0);
    rst_n = 1'b1;

    // tag, en, speeds, nack, drop, delay, hold, stop, ok, ovr, wait
    run_frame("all_en",  8'hFF, 64'h1122334455667788, 7'h00, 7'h00, 3,  0, 7'h00, 8'hFF, 0, 3);
    run_frame("en_05",   8'h05, 64'hA1B2C3D4E5F60718, 7'h00, 7'h00, 3,  0, 7'h00, 8'h05, 0, 3);
    run_frame("nack_m2", 8'hFF, 64'h0F1E2D3C4B5A6978, 7'h2A, 7'h00, 3,  0, 7'h00, 8'hFD, 0, 3);
    run_frame("hold50",  8'h01, 64'h5500000000000000, 7'h00, 7'h00, 3, 50, 7'h00, 8'h01, 0, 3);
    run_frame("tmo_m3",  8'h0C, 64'h0000334400000000, 7'h00, 7'h2B, 3,  0, 7'h00, 8'h08, 0, TIMEOUT);
    run_frame("overrun", 8'hFF, 64'h8877665544332211, 7'h00, 7'h00, 14, 0, 7'h00, 8'hFF, 1, 14);
    run_frame("men_off", 8'hFF, 64'h0102030405060708, 7'h29, 7'h00, 3,  0, 7'h2A, 8'hFE, 0, 3);

    // reset asserted while waiting for motor 1's done
    motor_en   = 8'hFF;
    speed_flat = 64'hC1C2C3C4C5C6C7C8;
    nack_a     = 7'h0;
    drop_a     = 7'h0;
    done_delay = 10;
    wr_ready   = 1'b1;
    master_en  = 1'b1;
    exp_q.push_back({7'h29, 8'hC1});
    n = 0;
    while (!(o_wr_valid && wr_ready) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) bad("rst_issue");
    @(posedge clk);
    #2;
    check("rst_pre_state_wait", o_dbg_state, 3'd4);
    rst_n = 1'b0;
    #1;
    check("rst_wr_valid", o_wr_valid, 1'b0);
    check("rst_wr_addr", o_wr_addr, 7'h0);
    check("rst_wr_data", o_wr_data, 8'h0);
    check("rst_motor_ok", o_motor_ok, 8'h0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_state", o_dbg_state, 3'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    check("rst_writes_left", exp_q.size(), 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_wr_valid || o_busy) n++;
    end
    check("rst_quiet_until_tick", n, 0);

    run_frame("en_00",   8'h00, 64'h1111111111111111, 7'h00, 7'h00, 3,  0, 7'h00, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got=no finish expected=finish before time limit");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
